clock_ctrl: RTL and testbench
=============================

// Module: clock_ctrl
// PURPOSE
//   Timekeeping controller for the 6-digit HH:MM:SS display.
//   - Divides the system clock to a 1 Hz tick and keeps BCD seconds, minutes and hours (24 h).
//   - Sequences a button-driven set mode.
//   - Drives the six 4-bit digit inputs of the seven-segment decoder.
//   - Blanks the field being set by driving 4'hF, which the decoder shows as all segments off.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per 1 s tick (>=2)
//   BLINK_DIV  25_000_000  clk cycles per blink phase toggle (>=1)
// PORTS
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   btn_mode  in   1  mode button, level, already debounced, synchronous to clk
//   btn_inc   in   1  increment button, level, already debounced, synchronous to clk
//   sec_lo    out  4  seconds units digit, BCD, or 4'hF when blanked
//   sec_hi    out  4  seconds tens digit
//   min_lo    out  4  minutes units digit
//   min_hi    out  4  minutes tens digit
//   hour_lo   out  4  hours units digit
//   hour_hi   out  4  hours tens digit
//   mode      out  2  current state: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
//   tick      out  1  one-cycle pulse on each 1 s tick (RUN only)
// BEHAVIOUR
// - Reset (async assert, sync release): all of the following are cleared.
//     - Time is 00:00:00 and mode is RUN.
//     - Prescaler and blink counter are 0; blink phase is 0.
//     - Button history registers are 0; tick is 0.
//     - All digit outputs are 0.
// - Button events:
//     - press_x = btn_x & ~btn_x_q, where btn_x_q is btn_x registered.
//     - A held button gives exactly one event.
//     - An event takes effect on the same clock edge on which it is detected.
// - Prescaler (RUN only):
//     - Counts 0..TICK_DIV-1.
//     - At TICK_DIV-1 it returns to 0 and tick=1 for that cycle; the time update happens on that edge.
//     - Outside RUN the prescaler is held at 0.
//     - The first tick after re-entering RUN comes exactly TICK_DIV cycles later.
// - Time update on tick (BCD, per-digit carry):
//     - sec_lo 9->0 carries into sec_hi; sec 59->00 carries into minutes.
//     - min 59->00 carries into hours.
//     - hour 23->00 wraps with no further carry.
//     - Binary values never appear on the digit outputs.
// - FSM, advanced by press_mode: RUN -> SET_H -> SET_M -> SET_S -> RUN.
// - In SET_x:
//     - Time is frozen and no tick is generated.
//     - press_inc increments the selected field by 1 with wrap: hour 23->00, min/sec 59->00.
//     - Set-mode increments never carry into other fields.
//     - In RUN, press_inc is ignored.
// - Simultaneous press_mode and press_inc: the mode change wins and the increment is dropped.
// - Blink:
//     - The blink counter runs freely in all states and toggles the phase every BLINK_DIV cycles.
//     - In SET_x with phase=1, both digits of the selected field output 4'hF.
//     - All other digits, and all digits in RUN, show the true values.
// - Digit outputs are combinational from the time registers, the state and the blink phase.
//   There is no extra pipeline latency: a register update is visible the cycle after the edge.
// - Reset mid-set returns immediately to RUN at 00:00:00; the partial setting is discarded.
// TESTING  (bench uses TICK_DIV=4, BLINK_DIV=2)
// - Reset: release rst_n, hold buttons low for 20 cycles.
//     -> Digits go 000000 then count one second every 4 cycles; tick is a one-cycle pulse every 4 cycles.
// - Rollover: set 23:59:59, return to RUN, wait one tick.
//     -> 00:00:00 with no intermediate non-BCD value.
//     -> Likewise 00:00:59 -> 00:01:00 and 00:09:59 -> 00:10:00.
// - Set hours: 1 mode press, then 25 inc presses from hour 00.
//     -> mode=1 and hour=01; seconds and minutes unchanged over 40 idle cycles.
// - Blink: in SET_M with minutes 42.
//     -> min_hi/min_lo alternate 4/2 and F/F every 2 cycles; other digits are steady.
// - Button edges:
//     - Hold btn_inc for 10 cycles in SET_S -> exactly +1.
//     - Raise mode and inc on the same cycle in SET_S -> mode=RUN, seconds unchanged.
// - Reset mid-set: assert rst_n=0 during SET_M at 12:34:xx.
//     -> Outputs become 00:00:00 and mode=0 asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/clock_ctrl_if.sv
// Button inputs and six-digit display / status outputs of the timekeeping controller.
// The driver side (buttons) is the master; the controller side is the slave.
interface clock_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic [3:0] hour_lo;
    logic [3:0] hour_hi;
    logic [1:0] mode;
    logic       tick;

    modport master (
        output btn_mode, btn_inc,
        input  sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi, mode, tick
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi, mode, tick
    );
endinterface

// File: rtl/clock_ctrl.sv
// BCD HH:MM:SS clock with 1 Hz prescaler, button set mode and blinking of the field being set.
// Latency: digits change the cycle after the updating edge; no backpressure, buttons are edge-detected levels.
module clock_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    clock_ctrl_if.slave  io_bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_btn_mode_q, r_btn_inc_q;
    logic [PW-1:0]   r_presc;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_phase;
    logic [3:0]      r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
    logic [3:0]      w_s0, w_s1, w_m0, w_m1, w_h0, w_h1;
    logic            w_press_mode, w_press_inc, w_tick;
    logic [8:0]      w_sec_inc, w_min_inc;
    logic [7:0]      w_hr_inc;

    // Returns {wrapped, hi, lo} for a 00..59 BCD field.
    function automatic logic [8:0] inc59(input logic [3:0] hi, input logic [3:0] lo);
        if (lo != 4'd9)      return {1'b0, hi, lo + 4'd1};
        else if (hi != 4'd5) return {1'b0, hi + 4'd1, 4'd0};
        else                 return 9'd0 | 9'h100;
    endfunction

    function automatic logic [7:0] inc23(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == 4'd2 && lo == 4'd3) return 8'h00;
        else if (lo == 4'd9)          return {hi + 4'd1, 4'd0};
        else                          return {hi, lo + 4'd1};
    endfunction

    assign w_press_mode = io_bus.btn_mode & ~r_btn_mode_q;
    assign w_press_inc  = io_bus.btn_inc  & ~r_btn_inc_q;
    assign w_tick       = (r_state == RUN) && (r_presc == P_MAX);
    assign w_sec_inc    = inc59(r_s1, r_s0);
    assign w_min_inc    = inc59(r_m1, r_m0);
    assign w_hr_inc     = inc23(r_h1, r_h0);

    always_comb begin
        w_state_nxt = r_state;
        w_s0 = r_s0; w_s1 = r_s1;
        w_m0 = r_m0; w_m1 = r_m1;
        w_h0 = r_h0; w_h1 = r_h1;
        if (w_press_mode)
            w_state_nxt = state_t'(r_state + 2'd1);
        // Carries ripple only on a run tick; set-mode increments stay inside their field.
        if (w_tick) begin
            {w_s1, w_s0} = w_sec_inc[7:0];
            if (w_sec_inc[8]) begin
                {w_m1, w_m0} = w_min_inc[7:0];
                if (w_min_inc[8])
                    {w_h1, w_h0} = w_hr_inc;
            end
        end else if (w_press_inc && !w_press_mode) begin
            case (r_state)
                SET_H:   {w_h1, w_h0} = w_hr_inc;
                SET_M:   {w_m1, w_m0} = w_min_inc[7:0];
                SET_S:   {w_s1, w_s0} = w_sec_inc[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_btn_mode_q <= 1'b0;
            r_btn_inc_q  <= 1'b0;
            r_presc      <= '0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_s0 <= 4'd0; r_s1 <= 4'd0;
            r_m0 <= 4'd0; r_m1 <= 4'd0;
            r_h0 <= 4'd0; r_h1 <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_btn_mode_q <= io_bus.btn_mode;
            r_btn_inc_q  <= io_bus.btn_inc;
            if (r_state != RUN || w_press_mode || r_presc == P_MAX)
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;
            if (r_blink_cnt == B_MAX) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_s0 <= w_s0; r_s1 <= w_s1;
            r_m0 <= w_m0; r_m1 <= w_m1;
            r_h0 <= w_h0; r_h1 <= w_h1;
        end
    end

    logic w_blank_h, w_blank_m, w_blank_s;
    assign w_blank_h = r_phase && (r_state == SET_H);
    assign w_blank_m = r_phase && (r_state == SET_M);
    assign w_blank_s = r_phase && (r_state == SET_S);

    assign io_bus.hour_hi = w_blank_h ? 4'hF : r_h1;
    assign io_bus.hour_lo = w_blank_h ? 4'hF : r_h0;
    assign io_bus.min_hi  = w_blank_m ? 4'hF : r_m1;
    assign io_bus.min_lo  = w_blank_m ? 4'hF : r_m0;
    assign io_bus.sec_hi  = w_blank_s ? 4'hF : r_s1;
    assign io_bus.sec_lo  = w_blank_s ? 4'hF : r_s0;
    assign io_bus.mode    = r_state;
    assign io_bus.tick    = w_tick;
endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: seconds-of-day reference model checked every cycle, plus directed literal checks.
module tb_clock_ctrl;
    localparam int TD = 4;
    localparam int BD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_ctrl_if bus ();

    clock_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: time as seconds since midnight, edges since reset, edges spent in RUN.
    typedef struct {
        int   t;
        int   mode;
        int   run;
        int   cyc;
        logic pm_q;
        logic pi_q;
    } mstate_t;

    mstate_t m = '{default: 0};

    function automatic mstate_t mstep(mstate_t s, logic bm, logic bi);
        mstate_t n = s;
        logic pm = bm & ~s.pm_q;
        logic pi = bi & ~s.pi_q;
        int h  = s.t / 3600;
        int mi = (s.t / 60) % 60;
        int sc = s.t % 60;
        n.pm_q = bm;
        n.pi_q = bi;
        n.cyc  = s.cyc + 1;
        if (s.mode == 0 && (s.run % TD) == TD - 1)
            n.t = (s.t + 1) % 86400;
        if (pm) begin
            n.mode = (s.mode + 1) % 4;
            n.run  = 0;
        end else begin
            if (pi) begin
                if (s.mode == 1) h  = (h + 1) % 24;
                if (s.mode == 2) mi = (mi + 1) % 60;
                if (s.mode == 3) sc = (sc + 1) % 60;
                if (s.mode != 0) n.t = h * 3600 + mi * 60 + sc;
            end
            if (s.mode == 0) n.run = s.run + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= mstep(m, bus.btn_mode, bus.btn_inc);
    end

    function automatic logic [26:0] exp_vec();
        logic [3:0] d [6];
        int   h  = m.t / 3600;
        int   mi = (m.t / 60) % 60;
        int   sc = m.t % 60;
        bit   ph = ((m.cyc / BD) % 2) == 1;
        bit   tk = (m.mode == 0) && ((m.run % TD) == TD - 1);
        d[5] = 4'(h / 10);  d[4] = 4'(h % 10);
        d[3] = 4'(mi / 10); d[2] = 4'(mi % 10);
        d[1] = 4'(sc / 10); d[0] = 4'(sc % 10);
        if (ph && m.mode == 1) begin d[5] = 4'hF; d[4] = 4'hF; end
        if (ph && m.mode == 2) begin d[3] = 4'hF; d[2] = 4'hF; end
        if (ph && m.mode == 3) begin d[1] = 4'hF; d[0] = 4'hF; end
        return {2'(m.mode), tk, d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [23:0] digits();
        return {bus.hour_hi, bus.hour_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic press(bit is_mode);
        if (is_mode) bus.btn_mode = 1'b1;
        else         bus.btn_inc  = 1'b1;
        step(1);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step(1);
    endtask

    task automatic set_time(int h, int mi, int sc);
        do_reset();
        press(1); repeat (h)  press(0);
        press(1); repeat (mi) press(0);
        press(1); repeat (sc) press(0);
        press(1);
    endtask

    // Digit snapshot taken on a cycle where no field is blanked.
    task automatic get_unblanked(string name, output logic [23:0] v);
        bit ok = 1'b0;
        v = digits();
        for (int i = 0; i < 4 && !ok; i++) begin
            v = digits();
            if (v[23:20] != 4'hF && v[15:12] != 4'hF && v[7:4] != 4'hF) ok = 1'b1;
            else step(1);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unblank: got %0h want no F digit", name, v);
        end
    endtask

    initial begin
        logic [23:0] v;
        int n_tick, n42, nff;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_en = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) check("cycle_model", {bus.mode, bus.tick, digits()}, exp_vec());
            end
        join_none

        check("rst_digits", digits(), 24'h000000);
        check("rst_mode", bus.mode, 0);
        check("rst_tick", bus.tick, 0);

        do_reset();
        n_tick = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.tick) n_tick++;
        end
        check("run_20_ticks", n_tick, 5);
        check("run_20_time", digits(), 24'h000005);

        set_time(23, 59, 59);
        step(2);
        check("pre_roll_235959", digits(), 24'h235959);
        step(1);
        check("roll_235959", digits(), 24'h000000);

        set_time(0, 0, 59);
        step(3);
        check("roll_000059", digits(), 24'h000100);

        set_time(0, 9, 59);
        step(3);
        check("roll_000959", digits(), 24'h001000);

        do_reset();
        press(1);
        repeat (25) press(0);
        get_unblanked("set_h", v);
        check("set_h_hour", v, 24'h010000);
        check("set_h_mode", bus.mode, 1);
        step(40);
        get_unblanked("set_h_idle", v);
        check("set_h_idle", v, 24'h010000);

        do_reset();
        press(1); press(1);
        repeat (42) press(0);
        n42 = 0; nff = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if ({bus.min_hi, bus.min_lo} == 8'h42) n42++;
            else if ({bus.min_hi, bus.min_lo} == 8'hFF) nff++;
        end
        check("blink_42", n42, 4);
        check("blink_ff", nff, 4);

        do_reset();
        press(1); press(1); press(1);
        repeat (5) press(0);
        bus.btn_inc = 1'b1;
        step(10);
        bus.btn_inc = 1'b0;
        step(1);
        get_unblanked("hold_inc", v);
        check("hold_inc_sec", v, 24'h000006);
        check("hold_inc_mode", bus.mode, 3);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        step(1);
        check("simul_mode", bus.mode, 0);
        check("simul_sec", {bus.sec_hi, bus.sec_lo}, 8'h06);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step(1);

        do_reset();
        press(1); repeat (12) press(0);
        press(1); repeat (34) press(0);
        get_unblanked("mid_set", v);
        check("mid_set_time", v[23:8], 16'h1234);
        check("mid_set_mode", bus.mode, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_digits", digits(), 24'h000000);
        check("rst_async_mode", bus.mode, 0);
        step(2);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bus.btn_mode = ($urandom_range(0, 29) == 0);
            bus.btn_inc  = ($urandom_range(0, 3) == 0);
            step(1);
        end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
